imem_arb: RTL and testbench
===========================

IMEM_ARB -- requirements
Module: imem_arb

Interface
REQ-001 SHALL have parameter ADDR_W, default 30, word-address width.
REQ-002 SHALL have parameter STARVE_LIMIT, default 4, consecutive CPU wins tolerated while a burst read is pending (range 1..15).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port cpu_req  input  1  CPU fetch request; held with cpu_addr until granted.
REQ-006 SHALL have port cpu_addr  input  ADDR_W  CPU fetch word address.
REQ-007 SHALL have port cpu_gnt  output  1  combinational grant for the current cycle.
REQ-008 SHALL have port cpu_rvalid  output  1  registered; cpu_rdata valid.
REQ-009 SHALL have port cpu_rdata  output  32  instruction word for the CPU.
REQ-010 SHALL have port dbg_start  input  1  single-cycle burst-copy start pulse.
REQ-011 SHALL have port dbg_base  input  ADDR_W  burst base word address, sampled on accepted dbg_start.
REQ-012 SHALL have port dbg_len  input  5  burst length in words (1..16), sampled with dbg_base.
REQ-013 SHALL have port dbg_busy  output  1  high while a burst is active.
REQ-014 SHALL have port dbg_rvalid  output  1  registered; dbg_rdata/dbg_ridx valid.
REQ-015 SHALL have port dbg_rdata  output  32  burst word.
REQ-016 SHALL have port dbg_ridx  output  4  word index within the burst (0..len-1).
REQ-017 SHALL have port dbg_done  output  1  single-cycle pulse after the last burst word is returned.
REQ-018 SHALL have port rom_addr  output  ADDR_W  address to the shared instruction ROM (ROM registers it; data next cycle).
REQ-019 SHALL have port rom_inst  input  32  ROM data, valid one cycle after rom_addr is sampled.

Function
REQ-020 SHALL implement burst FSM states IDLE, BURST, DRAIN, DONE.
REQ-021 IDLE: dbg_start with dbg_len in 1..16 SHALL capture base/len, clear issue index, go BURST; dbg_len 0 or 17..31 SHALL be ignored; dbg_start outside IDLE SHALL be ignored.
REQ-022 BURST: burst is "pending" every cycle; each cycle the burst wins, rom_addr SHALL be base+idx (mod 2^ADDR_W) and idx SHALL increment; after issuing idx=len-1 SHALL go DRAIN.
REQ-023 DRAIN: one cycle, last dbg_rvalid asserted; then DONE. DONE: dbg_done=1 for one cycle; then IDLE.
REQ-024 dbg_busy SHALL be 1 in BURST, DRAIN, DONE; 0 in IDLE.
REQ-025 Arbitration per cycle: CPU wins if cpu_req and not (pending and starve_cnt==STARVE_LIMIT); else burst wins if pending; else no grant.
REQ-026 starve_cnt (4 bits) SHALL increment when CPU wins while pending, clear when burst wins or nothing pending; never exceeds STARVE_LIMIT.
REQ-027 cpu_gnt SHALL equal cpu_req AND CPU-wins, combinationally in the same cycle.
REQ-028 rom_addr SHALL be the winner's address; with no winner it SHALL hold the last issued address.
REQ-029 Latency: grant in cycle N SHALL produce exactly one rvalid to that requester in cycle N+1 with rdata = rom_inst; owner tracked by a registered tag.
REQ-030 cpu_rdata/dbg_rdata SHALL hold their last value when rvalid is 0.
REQ-031 At most one of cpu_rvalid, dbg_rvalid SHALL be 1 in any cycle.
REQ-032 dbg_start coincident with cpu_req in IDLE: CPU SHALL be granted that cycle; first burst issue no earlier than next cycle.

Reset
REQ-033 On rst: state IDLE, idx 0, starve_cnt 0, owner tag none, cpu_gnt follows REQ-027 with no burst pending, cpu_rvalid 0, dbg_rvalid 0, cpu_rdata 0, dbg_rdata 0, dbg_ridx 0, dbg_busy 0, dbg_done 0, rom_addr 0.
REQ-034 rst mid-burst SHALL abort it without dbg_done; any in-flight return SHALL be dropped (no rvalid the cycle after rst).

Verification
REQ-035 CPU only: cpu_req=1, cpu_addr 0,1,2 on successive gnts -> cpu_gnt=1 each cycle, cpu_rvalid next cycle with rdata 3c1d1000, 0c001403, 37bd7000.
REQ-036 Burst only: dbg_base=0x46, dbg_len=3 -> dbg_rvalid idx 0,1,2 with 27bdffd0, afbf002c, a3a40020 on consecutive cycles, dbg_done one cycle after idx 2, dbg_busy low after.
REQ-037 Starvation: cpu_req held high, burst len=2, STARVE_LIMIT=4 -> 4 CPU grants, 1 burst grant (cpu_gnt=0 that cycle), 4 CPU grants, 1 burst grant, then dbg_done.
REQ-038 Boundary: dbg_base=2^30-1, len=2 -> rom_addr 3FFFFFFF then 00000000; dbg_len=0 and dbg_start while busy -> no state change.
REQ-039 Reset mid-burst: assert rst with idx=5 of 16 -> next cycle dbg_busy=0, no rvalid, no dbg_done; new dbg_start accepted afterwards.

Source files
------------

// File: rtl/imem_arb.sv
// Instruction-ROM arbiter: shares one registered ROM port between CPU fetches and a
// debug burst-copy engine. CPU has priority, bounded by a starvation limit.
module imem_arb #(
  parameter int ADDR_W       = 30,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [31:0]       cpu_rdata,
  input  logic              dbg_start,
  input  logic [ADDR_W-1:0] dbg_base,
  input  logic [4:0]        dbg_len,
  output logic              dbg_busy,
  output logic              dbg_rvalid,
  output logic [31:0]       dbg_rdata,
  output logic [3:0]        dbg_ridx,
  output logic              dbg_done,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [31:0]       rom_inst
);

  typedef enum logic [1:0] {IDLE, BURST, DRAIN, DONE} state_t;
  typedef enum logic [1:0] {TAG_NONE, TAG_CPU, TAG_DBG} tag_t;

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  state_t              state_reg;
  tag_t                tag_reg;
  logic [ADDR_W-1:0]   base_reg;
  logic [ADDR_W-1:0]   last_addr_reg;
  logic [3:0]          last_idx_reg;
  logic [3:0]          idx_reg;
  logic [3:0]          starve_reg;
  logic [3:0]          ridx_reg;
  logic [31:0]         cpu_hold_reg;
  logic [31:0]         dbg_hold_reg;

  logic                pending;
  logic                cpu_win;
  logic                burst_win;
  logic                len_ok;
  logic [ADDR_W-1:0]   burst_addr;
  logic [4:0]          len_m1;

  // A grant seen while rst is high must not steal a burst slot.
  assign pending    = (state_reg == BURST) && !rst;
  assign cpu_win    = cpu_req && !(pending && (starve_reg == STARVE_MAX));
  assign burst_win  = pending && !cpu_win;
  assign cpu_gnt    = cpu_req && cpu_win;
  assign burst_addr = base_reg + ADDR_W'(idx_reg);
  assign len_ok     = (dbg_len != 5'd0) && (dbg_len <= 5'd16);
  assign len_m1     = dbg_len - 5'd1;

  always_comb begin
    rom_addr = last_addr_reg;
    if (rst)
      rom_addr = '0;
    else if (cpu_win)
      rom_addr = cpu_addr;
    else if (burst_win)
      rom_addr = burst_addr;
  end

  // Returns are steered by the owner tag of the previous cycle's grant; data is
  // the ROM output itself, with a hold register covering idle cycles.
  assign cpu_rvalid = (tag_reg == TAG_CPU);
  assign dbg_rvalid = (tag_reg == TAG_DBG);
  assign cpu_rdata  = cpu_rvalid ? rom_inst : cpu_hold_reg;
  assign dbg_rdata  = dbg_rvalid ? rom_inst : dbg_hold_reg;
  assign dbg_ridx   = ridx_reg;
  assign dbg_busy   = (state_reg != IDLE);
  assign dbg_done   = (state_reg == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      tag_reg       <= TAG_NONE;
      base_reg      <= '0;
      last_addr_reg <= '0;
      last_idx_reg  <= '0;
      idx_reg       <= '0;
      starve_reg    <= '0;
      ridx_reg      <= '0;
      cpu_hold_reg  <= '0;
      dbg_hold_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (dbg_start && len_ok) begin
            base_reg     <= dbg_base;
            last_idx_reg <= len_m1[3:0];
            idx_reg      <= '0;
            state_reg    <= BURST;
          end
        end
        BURST: begin
          if (burst_win) begin
            idx_reg <= idx_reg + 4'd1;
            if (idx_reg == last_idx_reg)
              state_reg <= DRAIN;
          end
        end
        DRAIN:   state_reg <= DONE;
        default: state_reg <= IDLE;
      endcase

      if (pending && cpu_win)
        starve_reg <= starve_reg + 4'd1;
      else
        starve_reg <= '0;

      if (cpu_win)
        tag_reg <= TAG_CPU;
      else if (burst_win)
        tag_reg <= TAG_DBG;
      else
        tag_reg <= TAG_NONE;

      if (burst_win)
        ridx_reg <= idx_reg;
      if (cpu_win || burst_win)
        last_addr_reg <= rom_addr;

      if (tag_reg == TAG_CPU)
        cpu_hold_reg <= rom_inst;
      if (tag_reg == TAG_DBG)
        dbg_hold_reg <= rom_inst;
    end
  end

endmodule

// File: tb/tb_imem_arb.sv
// Scoreboard bench for imem_arb: stimulus pushes expected returns, a monitor pops
// and compares on every rvalid; combinational outputs are checked inline.
module tb_imem_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req;
  logic [29:0] cpu_addr;
  logic        cpu_gnt;
  logic        cpu_rvalid;
  logic [31:0] cpu_rdata;
  logic        dbg_start;
  logic [29:0] dbg_base;
  logic [4:0]  dbg_len;
  logic        dbg_busy;
  logic        dbg_rvalid;
  logic [31:0] dbg_rdata;
  logic [3:0]  dbg_ridx;
  logic        dbg_done;
  logic [29:0] rom_addr;
  logic [31:0] rom_inst = 32'h0;

  int n_vec = 0;
  int n_err = 0;
  int exp_done = 0;
  int got_done = 0;

  logic [31:0] cpu_q[$];
  logic [35:0] dbg_q[$];

  always #5 clk = ~clk;

  imem_arb #(.ADDR_W(30), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_gnt(cpu_gnt),
    .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dbg_start(dbg_start), .dbg_base(dbg_base), .dbg_len(dbg_len),
    .dbg_busy(dbg_busy), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .dbg_ridx(dbg_ridx), .dbg_done(dbg_done),
    .rom_addr(rom_addr), .rom_inst(rom_inst)
  );

  function automatic logic [31:0] rom_fn(input logic [29:0] a);
    case (a)
      30'h0000_0000: rom_fn = 32'h3c1d1000;
      30'h0000_0001: rom_fn = 32'h0c001403;
      30'h0000_0002: rom_fn = 32'h37bd7000;
      30'h0000_0046: rom_fn = 32'h27bdffd0;
      30'h0000_0047: rom_fn = 32'hafbf002c;
      30'h0000_0048: rom_fn = 32'ha3a40020;
      30'h3FFF_FFFF: rom_fn = 32'hdeadbeef;
      default:       rom_fn = 32'h1000_0000 | {4'h0, a[27:0]};
    endcase
  endfunction

  // Registered ROM, one cycle of latency.
  always @(posedge clk) rom_inst <= rom_fn(rom_addr);

  task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops on every rvalid.
  always @(posedge clk) begin
    #1;
    if (cpu_rvalid === 1'b1 && dbg_rvalid === 1'b1)
      check("rvalid_exclusive", 36'd1, 36'd0);
    if (cpu_rvalid === 1'b1) begin
      if (cpu_q.size() == 0) check("cpu_unexpected_rvalid", {4'h0, cpu_rdata}, 36'hF_FFFF_FFFF);
      else begin
        check("cpu_rdata", {4'h0, cpu_rdata}, {4'h0, cpu_q[0]});
        $display("cpu return %h", cpu_rdata);
        void'(cpu_q.pop_front());
      end
    end
    if (dbg_rvalid === 1'b1) begin
      if (dbg_q.size() == 0) check("dbg_unexpected_rvalid", {dbg_ridx, dbg_rdata}, 36'hF_FFFF_FFFF);
      else begin
        check("dbg_ridx_rdata", {dbg_ridx, dbg_rdata}, dbg_q[0]);
        $display("dbg return idx %0d %h", dbg_ridx, dbg_rdata);
        void'(dbg_q.pop_front());
      end
    end
    if (dbg_done === 1'b1) got_done++;
  end

  logic [31:0] cpu_tab [3] = '{32'h3c1d1000, 32'h0c001403, 32'h37bd7000};
  logic        starve_pat [11] = '{1, 1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

  initial begin
    int burst_j;
    rst = 1'b1; cpu_req = 1'b0; cpu_addr = '0;
    dbg_start = 1'b0; dbg_base = '0; dbg_len = '0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_rom_addr", {6'h0, rom_addr}, 36'h0);
    check("rst_busy_done", {34'h0, dbg_busy, dbg_done}, 36'h0);
    check("rst_rvalid", {34'h0, cpu_rvalid, dbg_rvalid}, 36'h0);
    check("rst_cpu_rdata", {4'h0, cpu_rdata}, 36'h0);
    check("rst_dbg_rdata_ridx", {dbg_ridx, dbg_rdata}, 36'h0);
    check("rst_gnt", {35'h0, cpu_gnt}, 36'h0);
    @(negedge clk); rst = 1'b0;

    // CPU-only fetches.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      cpu_req = 1'b1; cpu_addr = 30'(i);
      #1;
      check("cpu_gnt", {35'h0, cpu_gnt}, 36'h1);
      check("cpu_rom_addr", {6'h0, rom_addr}, 36'(i));
      cpu_q.push_back(cpu_tab[i]);
      $display("cpu fetch addr %0d", i);
    end
    @(negedge clk); cpu_req = 1'b0; #1;
    check("cpu_gnt_idle", {35'h0, cpu_gnt}, 36'h0);
    check("rom_addr_hold", {6'h0, rom_addr}, 36'h2);

    // Burst only.
    @(negedge clk);
    dbg_start = 1'b1; dbg_base = 30'h46; dbg_len = 5'd3;
    dbg_q.push_back({4'd0, 32'h27bdffd0});
    dbg_q.push_back({4'd1, 32'hafbf002c});
    dbg_q.push_back({4'd2, 32'ha3a40020});
    exp_done++;
    $display("burst start base 46 len 3");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); dbg_start = 1'b0; #1;
      check("burst_busy", {35'h0, dbg_busy}, 36'h1);
      check("burst_rom_addr", {6'h0, rom_addr}, 36'h46 + 36'(k));
    end
    @(negedge clk); #1;
    check("drain_busy_done", {34'h0, dbg_busy, dbg_done}, 36'h2);
    @(negedge clk); #1;
    check("done_pulse", {34'h0, dbg_busy, dbg_done}, 36'h3);
    @(negedge clk); #1;
    check("after_done", {34'h0, dbg_busy, dbg_done}, 36'h0);

    // Starvation: CPU held high with a coincident burst start.
    @(negedge clk);
    cpu_req = 1'b1; cpu_addr = 30'h2;
    dbg_start = 1'b1; dbg_base = 30'h46; dbg_len = 5'd2;
    dbg_q.push_back({4'd0, 32'h27bdffd0});
    dbg_q.push_back({4'd1, 32'hafbf002c});
    exp_done++;
    burst_j = 0;
    for (int c = 0; c < 11; c++) begin
      if (c != 0) @(negedge clk);
      if (c == 1) dbg_start = 1'b0;
      #1;
      check("starve_gnt", {35'h0, cpu_gnt}, {35'h0, starve_pat[c]});
      if (starve_pat[c]) begin
        check("starve_cpu_addr", {6'h0, rom_addr}, 36'h2);
        cpu_q.push_back(32'h37bd7000);
      end else begin
        check("starve_burst_addr", {6'h0, rom_addr}, 36'h46 + 36'(burst_j));
        burst_j++;
      end
      $display("starve cycle %0d gnt %0d", c, cpu_gnt);
    end
    @(negedge clk); cpu_req = 1'b0;
    @(negedge clk); #1;
    check("starve_done", {35'h0, dbg_done}, 36'h1);
    @(negedge clk); #1;
    check("starve_busy_low", {35'h0, dbg_busy}, 36'h0);

    // Address wrap at the top of the word space.
    @(negedge clk);
    dbg_start = 1'b1; dbg_base = 30'h3FFF_FFFF; dbg_len = 5'd2;
    dbg_q.push_back({4'd0, 32'hdeadbeef});
    dbg_q.push_back({4'd1, 32'h3c1d1000});
    exp_done++;
    @(negedge clk); dbg_start = 1'b0; #1;
    check("wrap_addr0", {6'h0, rom_addr}, 36'h3FFF_FFFF);
    @(negedge clk); #1;
    check("wrap_addr1", {6'h0, rom_addr}, 36'h0);
    repeat (3) @(negedge clk);

    // Illegal lengths are ignored.
    for (int l = 0; l < 2; l++) begin
      @(negedge clk);
      dbg_start = 1'b1; dbg_base = 30'h46; dbg_len = (l == 0) ? 5'd0 : 5'd17;
      @(negedge clk); dbg_start = 1'b0; #1;
      check("bad_len_busy", {35'h0, dbg_busy}, 36'h0);
      $display("ignored start len %0d", dbg_len);
    end

    // Reset mid-burst, with a start pulse while busy that must be ignored.
    @(negedge clk);
    dbg_start = 1'b1; dbg_base = 30'h100; dbg_len = 5'd16;
    for (int k = 0; k < 5; k++)
      dbg_q.push_back({4'(k), 32'h1000_0100 + 32'(k)});
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      dbg_start = (k == 1);
      if (k == 1) begin dbg_base = 30'h46; dbg_len = 5'd3; end
      #1;
      check("long_burst_addr", {6'h0, rom_addr}, 36'h100 + 36'(k));
    end
    @(negedge clk); dbg_start = 1'b0; rst = 1'b1;
    @(negedge clk); rst = 1'b0; #1;
    check("abort_busy_done", {34'h0, dbg_busy, dbg_done}, 36'h0);
    check("abort_rvalid", {34'h0, cpu_rvalid, dbg_rvalid}, 36'h0);
    @(negedge clk);
    dbg_start = 1'b1; dbg_base = 30'h46; dbg_len = 5'd1;
    dbg_q.push_back({4'd0, 32'h27bdffd0});
    exp_done++;
    @(negedge clk); dbg_start = 1'b0; #1;
    check("restart_busy", {35'h0, dbg_busy}, 36'h1);
    check("restart_addr", {6'h0, rom_addr}, 36'h46);

    for (int t = 0; t < 50 && (cpu_q.size() != 0 || dbg_q.size() != 0); t++)
      @(negedge clk);
    repeat (3) @(negedge clk);
    check("cpu_queue_drained", 36'(cpu_q.size()), 36'h0);
    check("dbg_queue_drained", 36'(dbg_q.size()), 36'h0);
    check("done_count", 36'(got_done), 36'(exp_done));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
